// File: rtl/iic_pkg.sv
// Shared definitions for the IIC register-write sequencer.
// Holds the sequencer state encoding, the byte width, the R/W bit value used
// for writes, and the default bus-free gap for a 400 kHz bus clocked at 10 ns.
package iic_pkg;

  localparam int unsigned ByteW    = 8;
  localparam logic        WriteBit = 1'b0;

  // tBUF >= 1.3 us between STOP and the next START, at a 10 ns system clock.
  localparam int unsigned ClkPeriodNs       = 10;
  localparam int unsigned TbufNs            = 1300;
  localparam int unsigned BusFreeClocksDflt = (TbufNs + ClkPeriodNs - 1) / ClkPeriodNs;

  typedef enum logic [2:0] {
    StIdle,
    StDev,
    StReg,
    StDat,
    StWaitDone,
    StGap
  } iic_wr_state_e;

endpackage

// File: rtl/iic_timeout_cnt.sv
// Watchdog for the register-write sequencer.
// Counts clocks while en is high; restarts on clr or on any change of lvl.
// expired is high on the Limit-th consecutive counted clock.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable (sequencer waiting on the transmitter)
//   clr      : restart request (byte transfer)
//   lvl      : level watched for toggles (tx_ready)
//   expired  : timeout reached this cycle
module iic_timeout_cnt #(
  parameter int unsigned Limit = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic lvl,
  output logic expired
);

  localparam logic [15:0] LimitM1 = 16'(Limit - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        lvl_q;
  logic        restart;

  assign restart = !en || clr || (lvl != lvl_q);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != LimitM1) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign expired = !restart && (cnt_q == LimitM1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl;
    end
  end

endmodule

// File: rtl/iic_reg_wr.sv
// IIC register-write sequencer feeding the IIC byte transmitter.
// Turns one request into {dev,W}(START), register address bytes (MSB first),
// up to DATA_BYTES data bytes (top byte first), STOP on the last byte, then
// holds a bus-free gap before pulsing done.
// Optional: define IIC_REG_WR_TIMEOUT_EN to add a tx_ready watchdog that
// aborts with done+err after TIMEOUT_CLOCKS; otherwise err is tied low.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : request handshake; req_* captured on accept
//   req_dev_addr       : 7-bit slave address
//   req_reg_addr       : register address, MSB byte first
//   req_data, req_len  : data bytes (top byte first) and count (clamped)
//   busy, done, err    : status; done/err are one-cycle pulses
//   tx_data/start/stop/valid, tx_ready : byte interface to the transmitter
module iic_reg_wr
  import iic_pkg::*;
#(
  parameter int unsigned REG_ADDR_BYTES  = 1,
  parameter int unsigned DATA_BYTES      = 4,
  parameter int unsigned BUS_FREE_CLOCKS = BusFreeClocksDflt,
  parameter int unsigned TIMEOUT_CLOCKS  = 65535
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [6:0]                         req_dev_addr,
  input  logic [ByteW*REG_ADDR_BYTES-1:0]    req_reg_addr,
  input  logic [ByteW*DATA_BYTES-1:0]        req_data,
  input  logic [2:0]                         req_len,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [ByteW-1:0]                   tx_data,
  output logic                               tx_start,
  output logic                               tx_stop,
  output logic                               tx_valid,
  input  logic                               tx_ready
);

  localparam int unsigned RegW    = ByteW * REG_ADDR_BYTES;
  localparam int unsigned DatW    = ByteW * DATA_BYTES;
  localparam logic [2:0]  RegLast = 3'(REG_ADDR_BYTES - 1);
  localparam logic [2:0]  DatMax  = 3'(DATA_BYTES);
  localparam logic [15:0] GapMax  = 16'((BUS_FREE_CLOCKS == 0) ? 0 : BUS_FREE_CLOCKS - 1);

  iic_wr_state_e    state_q, state_d;
  logic [RegW-1:0]  reg_sr_q, reg_sr_d;
  logic [DatW-1:0]  dat_sr_q, dat_sr_d;
  logic [2:0]       len_q, len_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      gap_q, gap_d;
  logic             seen_low_q, seen_low_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_start_q, tx_start_d;
  logic             tx_stop_q, tx_stop_d;
  logic [ByteW-1:0] tx_data_q, tx_data_d;

  logic xfer;
  logic rearm;
  logic wd_expired;

  assign xfer  = tx_valid_q && tx_ready;
  // Transmitter has gone busy after the last byte and is idle again.
  assign rearm = !tx_valid_q && seen_low_q && tx_ready;

`ifdef IIC_REG_WR_TIMEOUT_EN
  logic wd_en;
  assign wd_en = (state_q == StDev) || (state_q == StReg) ||
                 (state_q == StDat) || (state_q == StWaitDone);

  iic_timeout_cnt #(
    .Limit(TIMEOUT_CLOCKS)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .en     (wd_en),
    .clr    (xfer),
    .lvl    (tx_ready),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CLOCKS;
`endif

  always_comb begin
    state_d    = state_q;
    reg_sr_d   = reg_sr_q;
    dat_sr_d   = dat_sr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    seen_low_d = seen_low_q;
    tx_valid_d = tx_valid_q;
    tx_start_d = tx_start_q;
    tx_stop_d  = tx_stop_q;
    tx_data_d  = tx_data_q;
    done       = 1'b0;
    err        = 1'b0;

    if (xfer) begin
      seen_low_d = 1'b0;
    end else if (!tx_valid_q && !tx_ready) begin
      seen_low_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d    = StDev;
          reg_sr_d   = req_reg_addr;
          dat_sr_d   = req_data;
          len_d      = (req_len > DatMax) ? DatMax : req_len;
          cnt_d      = '0;
          seen_low_d = 1'b0;
          tx_valid_d = 1'b1;
          tx_start_d = 1'b1;
          tx_stop_d  = 1'b0;
          tx_data_d  = {req_dev_addr, WriteBit};
        end
      end
      StDev: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          tx_start_d = 1'b0;
          cnt_d      = '0;
          state_d    = StReg;
        end
      end
      StReg: begin
        if (rearm) begin
          tx_valid_d = 1'b1;
          tx_data_d  = reg_sr_q[RegW-1 -: ByteW];
          reg_sr_d   = reg_sr_q << ByteW;
          tx_stop_d  = (cnt_q == RegLast) && (len_q == 3'd0);
        end else if (xfer) begin
          tx_valid_d = 1'b0;
          if (cnt_q == RegLast) begin
            cnt_d   = '0;
            state_d = (len_q == 3'd0) ? StWaitDone : StDat;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StDat: begin
        if (rearm) begin
          tx_valid_d = 1'b1;
          tx_data_d  = dat_sr_q[DatW-1 -: ByteW];
          dat_sr_d   = dat_sr_q << ByteW;
          tx_stop_d  = (cnt_q == len_q - 3'd1);
        end else if (xfer) begin
          tx_valid_d = 1'b0;
          if (cnt_q == len_q - 3'd1) begin
            state_d = StWaitDone;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StWaitDone: begin
        // STOP byte accepted; wait until the transmitter has released the bus.
        if (rearm) begin
          tx_stop_d = 1'b0;
          if (BUS_FREE_CLOCKS == 0) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == GapMax) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wd_expired) begin
      tx_valid_d = 1'b0;
      tx_start_d = 1'b0;
      tx_stop_d  = 1'b0;
      done       = 1'b1;
      err        = 1'b1;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      reg_sr_q   <= '0;
      dat_sr_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      seen_low_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      reg_sr_q   <= reg_sr_d;
      dat_sr_q   <= dat_sr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      seen_low_q <= seen_low_d;
      tx_valid_q <= tx_valid_d;
      tx_start_q <= tx_start_d;
      tx_stop_q  <= tx_stop_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign tx_valid  = tx_valid_q;
  assign tx_start  = tx_start_q;
  assign tx_stop   = tx_stop_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_iic_reg_wr.sv
// Bench for iic_reg_wr: request driver, transmitter model with a scoreboard
// of expected {start, stop, byte} entries, and directed checks on status.
module tb_iic_reg_wr;

  localparam int unsigned RAB = 2;
  localparam int unsigned DB  = 4;
  localparam int unsigned BFC = 5;
  localparam int unsigned TMO = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [6:0]      req_dev_addr;
  logic [8*RAB-1:0] req_reg_addr;
  logic [8*DB-1:0] req_data;
  logic [2:0]      req_len;
  logic            busy, done, err;
  logic [7:0]      tx_data;
  logic            tx_start, tx_stop, tx_valid;
  logic            tx_ready;

  iic_reg_wr #(
    .REG_ADDR_BYTES (RAB),
    .DATA_BYTES     (DB),
    .BUS_FREE_CLOCKS(BFC),
    .TIMEOUT_CLOCKS (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr),
    .req_data    (req_data),
    .req_len     (req_len),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_stop     (tx_stop),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_q[$];  // {start, stop, byte}
  int max_low = 1;
  bit stuck   = 1'b0;
  int ret_cyc = -1;      // cycle in which tx_ready returned after the STOP byte

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_req(input logic [6:0] dev, input logic [15:0] rg,
                          input logic [31:0] dat, input logic [2:0] len);
    int n;
    logic [7:0] b;
    n = (len > DB) ? DB : len;
    exp_q.push_back({1'b1, 1'b0, dev, 1'b0});
    for (int i = 0; i < RAB; i++) begin
      b = rg[8*(RAB-1-i) +: 8];
      exp_q.push_back({1'b0, (i == RAB - 1) && (n == 0), b});
    end
    for (int i = 0; i < n; i++) begin
      b = dat[8*(DB-1-i) +: 8];
      exp_q.push_back({1'b0, i == n - 1, b});
    end
  endtask

  // Transmitter model: accepts when idle, drops tx_ready the cycle after, stays low 1..max_low.
  initial begin
    int hold;
    bit xs;
    bit pv;
    bit last_stop;
    logic [9:0] pf;
    logic [9:0] e;
    hold = 0; xs = 1'b0; pv = 1'b0; last_stop = 1'b0; pf = '0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_ready = !stuck; hold = 0; xs = 1'b0; pv = 1'b0; last_stop = 1'b0;
        continue;
      end
      if (stuck) begin
        tx_ready = 1'b0; hold = 1; xs = 1'b0; pv = 1'b0; last_stop = 1'b0;
        continue;
      end
      if (pv && tx_valid) check("tx_stable", {tx_start, tx_stop, tx_data}, pf);
      if (xs) begin
        check("tx_valid_drop", tx_valid, 1'b0);
        tx_ready = 1'b0;
        hold = (max_low > 1) ? $urandom_range(max_low, 1) : 1;
        xs = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          tx_ready = 1'b1;
          if (last_stop) begin
            ret_cyc = cyc;
            last_stop = 1'b0;
          end
        end
      end else if (tx_valid && tx_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_byte observed=0x%0h expected=none", {tx_start, tx_stop, tx_data});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_byte", {tx_start, tx_stop, tx_data}, e);
        end
        xs = 1'b1;
        last_stop = tx_stop;
      end
      pv = tx_valid && !tx_ready;
      pf = {tx_start, tx_stop, tx_data};
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
  endtask

  task automatic issue(input logic [6:0] dev, input logic [15:0] rg,
                       input logic [31:0] dat, input logic [2:0] len);
    wait_ready();
    ret_cyc      = -1;
    req_dev_addr = dev;
    req_reg_addr = rg;
    req_data     = dat;
    req_len      = len;
    req_valid    = 1'b1;
    push_req(dev, rg, dat, len);
    @(negedge clk);
    req_valid = 1'b0;
    check("accept_ready_low", req_ready, 1'b0);
    check("accept_busy", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    check({tag, "_gap"}, cyc - ret_cyc, BFC);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    int n;
    int t0;
    logic [6:0] rd;
    logic [15:0] rr;
    logic [31:0] rdat;
    logic [2:0] rl;
    rst = 1'b1; req_valid = 1'b0;
    req_dev_addr = '0; req_reg_addr = '0; req_data = '0; req_len = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done_err", {done, err}, 2'b00);
    check("rst_tx", {tx_valid, tx_start, tx_stop, tx_data}, 11'h000);
    rst = 1'b0;
    @(negedge clk);

    max_low = 1;
    issue(7'h50, 16'h0010, 32'hA500_0000, 3'd1);
    wait_done("single");
    issue(7'h50, 16'h1234, 32'hDEAD_BEEF, 3'd4);
    wait_done("two_byte_addr");
    issue(7'h50, 16'h0007, 32'h0, 3'd0);
    wait_done("addr_only");
    issue(7'h3C, 16'hBEEF, 32'h0102_0304, 3'd7);
    wait_done("clamp");

    max_low = 50;
    for (int k = 0; k < 3; k++) begin
      rd = 7'($urandom); rr = 16'($urandom); rdat = $urandom; rl = 3'($urandom_range(4, 1));
      issue(rd, rr, rdat, rl);
      wait_done("backpressure");
    end

    // Requests while busy must be ignored.
    max_low = 3;
    issue(7'h11, 16'hA1A2, 32'h5566_7788, 3'd3);
    req_dev_addr = 7'h7F; req_reg_addr = 16'hFFFF; req_data = '1; req_len = 3'd2;
    req_valid = 1'b1;
    repeat (8) @(negedge clk);
    check("overlap_ready_low", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_done("overlap");
    repeat (3) @(negedge clk);
    check("overlap_not_queued", busy, 1'b0);

    // Reset in the middle of the data phase.
    max_low = 2;
    issue(7'h2A, 16'h0102, 32'hCAFE_F00D, 3'd4);
    n = 0;
    while (exp_q.size() > 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_dat", exp_q.size() <= 2, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    issue(7'h50, 16'h0042, 32'h9900_0000, 3'd1);
    wait_done("after_reset");

`ifdef IIC_REG_WR_TIMEOUT_EN
    stuck = 1'b1;
    repeat (3) @(negedge clk);
    issue(7'h22, 16'h0001, 32'h0, 3'd1);
    t0 = cyc;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_done", done, 1'b1);
    check("timeout_err", err, 1'b1);
    check("timeout_cycle", cyc - t0 + 1, TMO);
    @(negedge clk);
    check("timeout_idle", {busy, tx_valid, req_ready}, 3'b001);
    stuck = 1'b0;
    exp_q.delete();
`else
    t0 = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
